// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_feeder
// Description : FIFO-buffered sample streamer for the FIR input interface,
//               with programmable inter-sample gaps and an optional zero flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_feeder #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int TAPS   = 4,
    parameter int GAP_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              start,
    input  logic [GAP_W-1:0]  gap,
    input  logic              flush_en,
    output logic [DATA_W-1:0] io_in,
    output logic              io_valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sent_cnt
);

    localparam int c_ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W   = c_ADDR_W + 1;
    localparam int c_FLUSH_N = TAPS - 1;
    localparam int c_FLS_W   = $clog2(TAPS) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_GAP   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_flush_en;
    logic [c_FLS_W-1:0]  r_flush_cnt;
    logic [DATA_W-1:0]   r_io_in;
    logic                r_io_valid;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_sent_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_to_flush;

    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = wr_valid && !w_full;
    assign w_pop        = (r_state == S_SEND) && !w_empty;
    assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    // A one-tap FIR has nothing to flush, so the flush phase is skipped.
    assign w_to_flush   = r_flush_en && (c_FLUSH_N > 0);

    assign wr_ready = !w_full;
    assign io_in    = r_io_in;
    assign io_valid = r_io_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sent_cnt = r_sent_cnt;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_flush_en  <= 1'b0;
            r_flush_cnt <= '0;
            r_io_in     <= '0;
            r_io_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sent_cnt  <= '0;
        end else begin
            r_io_in    <= '0;
            r_io_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !w_empty) begin
                        r_state    <= S_SEND;
                        r_busy     <= 1'b1;
                        r_gap      <= gap;
                        r_flush_en <= flush_en;
                        r_sent_cnt <= '0;
                    end
                end
                S_SEND: begin
                    r_io_valid <= 1'b1;
                    r_io_in    <= r_mem[r_rd_ptr];
                    if (r_sent_cnt != 8'hFF) begin
                        r_sent_cnt <= r_sent_cnt + 8'd1;
                    end
                    if (w_count_next != '0) begin
                        if (r_gap != '0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= r_gap;
                        end
                    end else if (w_to_flush) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= c_FLS_W'(c_FLUSH_N);
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        if (!w_empty) begin
                            r_state <= S_SEND;
                        end else if (w_to_flush) begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= c_FLS_W'(c_FLUSH_N);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                S_FLUSH: begin
                    r_io_valid <= 1'b1;
                    if (r_flush_cnt <= c_FLS_W'(1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - c_FLS_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sample_feeder
// Description : Directed self-checking bench for fir_sample_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sample_feeder;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       start;
    logic [3:0] gap;
    logic       flush_en;
    logic [3:0] io_in;
    logic       io_valid;
    logic       busy;
    logic       done;
    logic [7:0] sent_cnt;

    int vectors    = 0;
    int miscompares = 0;

    fir_sample_feeder #(.DATA_W(4), .DEPTH(8), .TAPS(4), .GAP_W(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .start    (start),
        .gap      (gap),
        .flush_en (flush_en),
        .io_in    (io_in),
        .io_valid (io_valid),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] v);
        wr_data  = v;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic fire(input logic [3:0] g, input logic f);
        gap      = g;
        flush_en = f;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({io_valid, io_in, busy, done, sent_cnt} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%0b d=%0d b=%0b dn=%0b c=%0d, want all 0",
                     io_valid, io_in, busy, done, sent_cnt);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_wr_ready: got %0b want 1", wr_ready);
        end
    endtask

    task automatic test_flush_burst();
        logic [3:0] exp_d [9] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 6; i++) push(4'(2 * (i + 1)));
        fire(4'd0, 1'b1);
        vectors++;
        if (io_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_latency: got v=%0b busy=%0b want v=0 busy=1", io_valid, busy);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            vectors++;
            if (io_valid !== 1'b1 || io_in !== exp_d[i] || done !== 1'b0) begin
                miscompares++;
                $display("FAIL t1_beat%0d: got v=%0b d=%0d dn=%0b want v=1 d=%0d dn=0",
                         i, io_valid, io_in, done, exp_d[i]);
            end
        end
        tick();
        vectors++;
        if (done !== 1'b1 || io_valid !== 1'b0 || sent_cnt !== 8'd6 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_done: got dn=%0b v=%0b c=%0d b=%0b want dn=1 v=0 c=6 b=0",
                     done, io_valid, sent_cnt, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || sent_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL t1_after: got dn=%0b c=%0d want dn=0 c=6", done, sent_cnt);
        end
    endtask

    task automatic test_gap();
        logic       exp_v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_d [5] = '{4'd1, 4'd0, 4'd0, 4'd3, 4'd0};
        logic       exp_dn[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        push(4'd1);
        push(4'd3);
        fire(4'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (io_valid !== exp_v[i] || io_in !== exp_d[i] || done !== exp_dn[i]) begin
                miscompares++;
                $display("FAIL t2_cycle%0d: got v=%0b d=%0d dn=%0b want v=%0b d=%0d dn=%0b",
                         i, io_valid, io_in, done, exp_v[i], exp_d[i], exp_dn[i]);
            end
        end
        vectors++;
        if (sent_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL t2_sent_cnt: got %0d want 2", sent_cnt);
        end
    endtask

    task automatic test_full();
        int nbeats = 0;
        bit seen_done = 0;
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (wr_ready !== (i < 8)) begin
                miscompares++;
                $display("FAIL t3_ready_before_push%0d: got %0b want %0b", i, wr_ready, (i < 8));
            end
            push(4'(i + 1));
        end
        fire(4'd0, 1'b0);
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            if (io_valid) begin
                vectors++;
                if (io_in !== 4'(nbeats + 1)) begin
                    miscompares++;
                    $display("FAIL t3_beat%0d: got %0d want %0d", nbeats, io_in, nbeats + 1);
                end
                nbeats++;
            end
            if (done) seen_done = 1;
        end
        vectors++;
        if (!seen_done || nbeats != 8 || sent_cnt !== 8'd8) begin
            miscompares++;
            $display("FAIL t3_burst: got done=%0b beats=%0d c=%0d want done=1 beats=8 c=8",
                     seen_done, nbeats, sent_cnt);
        end
    endtask

    task automatic test_start_empty();
        int bad = 0;
        fire(4'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || io_valid !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL t4_empty_start: got %0d active cycles want 0", bad);
        end
        vectors++;
        if (sent_cnt !== 8'd8) begin
            miscompares++;
            $display("FAIL t4_sent_hold: got %0d want 8", sent_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        int bad = 0;
        for (int i = 0; i < 5; i++) push(4'(i + 1));
        fire(4'd0, 1'b0);
        tick();
        tick();
        vectors++;
        if (io_valid !== 1'b1 || io_in !== 4'd2) begin
            miscompares++;
            $display("FAIL t5_beat2: got v=%0b d=%0d want v=1 d=2", io_valid, io_in);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (io_valid !== 1'b0 || busy !== 1'b0 || sent_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL t5_async_reset: got v=%0b b=%0b c=%0d want 0 0 0",
                     io_valid, busy, sent_cnt);
        end
        tick();
        reset = 1'b0;
        fire(4'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || io_valid !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL t5_discarded: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        push(4'd7);
        fire(4'd0, 1'b0);
        wr_data  = 4'd9;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if (io_valid !== 1'b1 || io_in !== 4'd7) begin
            miscompares++;
            $display("FAIL t6_beat0: got v=%0b d=%0d want v=1 d=7", io_valid, io_in);
        end
        tick();
        vectors++;
        if (io_valid !== 1'b1 || io_in !== 4'd9) begin
            miscompares++;
            $display("FAIL t6_beat1: got v=%0b d=%0d want v=1 d=9", io_valid, io_in);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || io_valid !== 1'b0 || sent_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL t6_done: got dn=%0b v=%0b c=%0d want dn=1 v=0 c=2",
                     done, io_valid, sent_cnt);
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_data  = '0;
        wr_valid = 1'b0;
        start    = 1'b0;
        gap      = '0;
        flush_en = 1'b0;
        test_reset();
        test_flush_burst();
        test_gap();
        test_full();
        test_start_empty();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
